// File: rtl/synclk_pkg.sv
//==============================================================================
// Module      : synclk_pkg
// Description : Shared state encoding, default timing constants and a sizing
//               helper for the synclk lane scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package synclk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREDRIVE = 3'd1,
        ST_DRIVE    = 3'd2,
        ST_QUIESCE  = 3'd3,
        ST_RELEASE  = 3'd4
    } state_e;

    localparam int c_guard_cyc_dflt = 4;
    localparam int c_turn_cyc_dflt  = 8;
    localparam int c_max_hold_dflt  = 1024;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/synclk_rr_arb.sv
//==============================================================================
// Module      : synclk_rr_arb
// Description : Combinational round-robin picker; returns the first eligible
//               requester strictly after ptr, wrapping around.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module synclk_rr_arb
    import synclk_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int            cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        pick     = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Offset NREQ lands back on ptr itself, so it is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (!any && elig[cand_idx]) begin
                any            = 1'b1;
                idx            = cand_idx;
                pick[cand_idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/synclk_lane_sched.sv
//==============================================================================
// Module      : synclk_lane_sched
// Description : Arbitrates ownership of the shared synclk lanes and sequences
//               tristate / clock-enable with guard and turnaround time.
//               Optional hold-time limit enabled by SYNCLK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module synclk_lane_sched
    import synclk_pkg::*;
#(
    parameter int NLANE     = 4,
    parameter int NREQ      = 4,
    parameter int GUARD_CYC = c_guard_cyc_dflt,
    parameter int TURN_CYC  = c_turn_cyc_dflt,
    parameter int MAX_HOLD  = c_max_hold_dflt
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*NLANE-1:0]   lane_mask,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [NLANE-1:0]        tx_t,
    output logic [NLANE-1:0]        tx_en,
    output logic                    busy,
    output logic                    timeout
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(max3(GUARD_CYC, TURN_CYC, MAX_HOLD) + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic             ptr_vld_q, ptr_vld_d;
    logic [NLANE-1:0] mask_q, mask_d;
    logic [NLANE-1:0] tx_t_q, tx_t_d;
    logic [NLANE-1:0] tx_en_q, tx_en_d;
    logic             busy_q, busy_d;
`ifdef SYNCLK_TIMEOUT_EN
    logic [CW-1:0]    hold_q, hold_d;
    logic             timeout_q, timeout_d;
`endif

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  pick;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [IW-1:0]    ptr_eff;
    logic [NLANE-1:0] sel_mask;

    for (genvar i = 0; i < NREQ; i++) begin : g_elig
        assign elig[i] = req[i] & (|lane_mask[i*NLANE +: NLANE]);
    end

    // The owner register doubles as the round-robin pointer; before the first
    // grant the search starts after NREQ-1 so requester 0 is served first.
    assign ptr_eff = ptr_vld_q ? owner_q : IW'(NREQ - 1);

    synclk_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .elig (elig),
        .ptr  (ptr_eff),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                sel_mask = sel_mask | lane_mask[i*NLANE +: NLANE];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_vld_d = ptr_vld_q;
        mask_d    = mask_q;
        tx_t_d    = tx_t_q;
        tx_en_d   = tx_en_q;
        busy_d    = busy_q;
`ifdef SYNCLK_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d   = ST_PREDRIVE;
                    cnt_d     = CW'(GUARD_CYC - 1);
                    gnt_d     = pick;
                    owner_d   = pick_idx;
                    ptr_vld_d = 1'b1;
                    mask_d    = sel_mask;
                    tx_t_d    = ~sel_mask;
                    tx_en_d   = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_PREDRIVE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRIVE;
                    tx_en_d = mask_q;
`ifdef SYNCLK_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DRIVE: begin
                if (!req[owner_q]) begin
                    state_d = ST_QUIESCE;
                    cnt_d   = CW'(GUARD_CYC - 1);
                    tx_en_d = '0;
`ifdef SYNCLK_TIMEOUT_EN
                end else if (hold_q == CW'(MAX_HOLD - 1)) begin
                    state_d   = ST_QUIESCE;
                    cnt_d     = CW'(GUARD_CYC - 1);
                    tx_en_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
`endif
                end
            end
            ST_QUIESCE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = CW'(TURN_CYC - 1);
                    gnt_d   = '0;
                    tx_t_d  = '1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                tx_t_d  = '1;
                tx_en_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_vld_q <= 1'b0;
            mask_q    <= '0;
            tx_t_q    <= '1;
            tx_en_q   <= '0;
            busy_q    <= 1'b0;
`ifdef SYNCLK_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_vld_q <= ptr_vld_d;
            mask_q    <= mask_d;
            tx_t_q    <= tx_t_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
`ifdef SYNCLK_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign tx_t  = tx_t_q;
    assign tx_en = tx_en_q;
    assign busy  = busy_q;
`ifdef SYNCLK_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_synclk_lane_sched.sv
//==============================================================================
// Module      : tb_synclk_lane_sched
// Description : Directed self-checking bench for synclk_lane_sched; the
//               timeout scenario follows SYNCLK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_synclk_lane_sched;

    localparam int NLANE = 4;
    localparam int NREQ  = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] lane_mask;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [3:0]  tx_t;
    logic [3:0]  tx_en;
    logic        busy;
    logic        timeout;

    int total;
    int bad;

    synclk_lane_sched #(
        .NLANE     (NLANE),
        .NREQ      (NREQ),
        .GUARD_CYC (4),
        .TURN_CYC  (8),
        .MAX_HOLD  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lane_mask (lane_mask),
        .gnt       (gnt),
        .owner     (owner),
        .tx_t      (tx_t),
        .tx_en     (tx_en),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        lane_mask = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req       = '0;
        lane_mask = '0;
        tick();
        total++;
        if ({gnt, owner, tx_t, tx_en, busy, timeout} !== {4'b0000, 2'd0, 4'b1111, 4'b0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: gnt=%b owner=%0d tx_t=%b tx_en=%b busy=%b timeout=%b, want 0000 0 1111 0000 0 0",
                     gnt, owner, tx_t, tx_en, busy, timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        lane_mask[7:4] = 4'b0011;
        req            = 4'b0010;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 1) begin
                total++;
                if ({gnt, tx_t, tx_en, busy} !== {4'b0010, 4'b1100, 4'b0000, 1'b1}) begin
                    bad++;
                    $display("FAIL single_c1: gnt=%b tx_t=%b tx_en=%b busy=%b, want 0010 1100 0000 1", gnt, tx_t, tx_en, busy);
                end
            end
            if (c == 4) begin
                total++;
                if (tx_en !== 4'b0000) begin
                    bad++;
                    $display("FAIL single_c4_guard: tx_en=%b, want 0000", tx_en);
                end
            end
            if (c == 5) begin
                total++;
                if (tx_en !== 4'b0011) begin
                    bad++;
                    $display("FAIL single_c5_txen: tx_en=%b, want 0011", tx_en);
                end
            end
            if (c == 20) req = 4'b0000;
            if (c == 21) begin
                total++;
                if ({tx_en, tx_t, gnt} !== {4'b0000, 4'b1100, 4'b0010}) begin
                    bad++;
                    $display("FAIL single_c21: tx_en=%b tx_t=%b gnt=%b, want 0000 1100 0010", tx_en, tx_t, gnt);
                end
            end
            if (c == 24) begin
                total++;
                if ({tx_t, gnt} !== {4'b1100, 4'b0010}) begin
                    bad++;
                    $display("FAIL single_c24: tx_t=%b gnt=%b, want 1100 0010", tx_t, gnt);
                end
            end
            if (c == 25) begin
                total++;
                if ({tx_t, gnt, busy} !== {4'b1111, 4'b0000, 1'b1}) begin
                    bad++;
                    $display("FAIL single_c25: tx_t=%b gnt=%b busy=%b, want 1111 0000 1", tx_t, gnt, busy);
                end
            end
            if (c == 32) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL single_c32_busy: busy=%b, want 1", busy);
                end
            end
            if (c == 33) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL single_c33_busy: busy=%b, want 0", busy);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int          exp_order [5] = '{0, 1, 2, 3, 0};
        int          exp;
        int          guard;
        logic [3:0]  exp_gnt;
        do_reset();
        lane_mask = 16'b1000_0100_0010_0001;
        req       = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp     = exp_order[n];
            exp_gnt = 4'b0001 << exp;
            guard   = 0;
            while (gnt === 4'b0000 && guard < 60) begin
                tick();
                guard++;
            end
            total++;
            if (gnt !== exp_gnt || owner !== 2'(exp)) begin
                bad++;
                $display("FAIL rr_grant%0d: gnt=%b owner=%0d, want %b %0d", n, gnt, owner, exp_gnt, exp);
            end
            repeat (10) tick();
            req[exp] = 1'b0;
            guard    = 0;
            while (gnt !== 4'b0000 && guard < 40) begin
                tick();
                guard++;
            end
            total++;
            if (gnt !== 4'b0000) begin
                bad++;
                $display("FAIL rr_release%0d: gnt=%b, want 0000", n, gnt);
            end
            req[exp] = 1'b1;
        end
        req = '0;
    endtask

    task automatic test_zero_mask();
        int seen;
        do_reset();
        lane_mask[11:8]  = 4'b0000;
        lane_mask[15:12] = 4'b1000;
        req              = 4'b0100;
        seen             = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (gnt !== 4'b0000 || busy !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL zero_mask_idle: active cycles=%0d, want 0", seen);
        end
        req = 4'b1100;
        tick();
        total++;
        if ({gnt, owner, tx_t} !== {4'b1000, 2'd3, 4'b0111}) begin
            bad++;
            $display("FAIL zero_mask_grant3: gnt=%b owner=%0d tx_t=%b, want 1000 3 0111", gnt, owner, tx_t);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_drive();
        do_reset();
        lane_mask[7:4] = 4'b0011;
        req            = 4'b0010;
        repeat (8) tick();
        total++;
        if (tx_en !== 4'b0011) begin
            bad++;
            $display("FAIL midrst_drive: tx_en=%b, want 0011", tx_en);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({tx_t, tx_en, gnt, busy} !== {4'b1111, 4'b0000, 4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL midrst_async: tx_t=%b tx_en=%b gnt=%b busy=%b, want 1111 0000 0000 0", tx_t, tx_en, gnt, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({gnt, tx_t, busy} !== {4'b0010, 4'b1100, 1'b1}) begin
            bad++;
            $display("FAIL midrst_regrant: gnt=%b tx_t=%b busy=%b, want 0010 1100 1", gnt, tx_t, busy);
        end
        req = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        lane_mask[3:0] = 4'b0001;
        req            = 4'b0001;
`ifdef SYNCLK_TIMEOUT_EN
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 20) begin
                total++;
                if ({timeout, tx_en} !== {1'b0, 4'b0001}) begin
                    bad++;
                    $display("FAIL to_c20: timeout=%b tx_en=%b, want 0 0001", timeout, tx_en);
                end
            end
            if (c == 21) begin
                total++;
                if ({timeout, tx_en, gnt} !== {1'b1, 4'b0000, 4'b0001}) begin
                    bad++;
                    $display("FAIL to_c21_pulse: timeout=%b tx_en=%b gnt=%b, want 1 0000 0001", timeout, tx_en, gnt);
                end
            end
            if (c == 22) begin
                total++;
                if (timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL to_c22_pulse_end: timeout=%b, want 0", timeout);
                end
            end
            if (c == 25) begin
                total++;
                if ({gnt, tx_t} !== {4'b0000, 4'b1111}) begin
                    bad++;
                    $display("FAIL to_c25_release: gnt=%b tx_t=%b, want 0000 1111", gnt, tx_t);
                end
            end
            if (c == 33) begin
                total++;
                if ({gnt, busy} !== {4'b0000, 1'b0}) begin
                    bad++;
                    $display("FAIL to_c33_idle: gnt=%b busy=%b, want 0000 0", gnt, busy);
                end
            end
            if (c == 34) begin
                total++;
                if ({gnt, owner} !== {4'b0001, 2'd0}) begin
                    bad++;
                    $display("FAIL to_c34_regrant: gnt=%b owner=%0d, want 0001 0", gnt, owner);
                end
            end
        end
`else
        begin
            int n_to;
            int n_off;
            n_to  = 0;
            n_off = 0;
            for (int c = 1; c <= 1100; c++) begin
                tick();
                if (timeout !== 1'b0) n_to++;
                if (c >= 5 && tx_en !== 4'b0001) n_off++;
            end
            total++;
            if (n_to !== 0 || n_off !== 0) begin
                bad++;
                $display("FAIL no_to_hold: timeout cycles=%0d drive gaps=%0d, want 0 0", n_to, n_off);
            end
            total++;
            if ({gnt, busy} !== {4'b0001, 1'b1}) begin
                bad++;
                $display("FAIL no_to_still_owned: gnt=%b busy=%b, want 0001 1", gnt, busy);
            end
        end
`endif
        req = '0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req       = '0;
        lane_mask = '0;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_mask();
        test_reset_mid_drive();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
